// File: rtl/regfile_access_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_access_arbiter_pkg: shared types and defaults for the arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package regfile_access_arbiter_pkg;

  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// +----------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin pick with a last-winner register     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter2
  import regfile_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    valid_o = |req_i;
    // On a tie the requester that did not win last time goes first.
    if (req_i == 2'b11) begin
      winner_o = ~last_q;
    end else begin
      winner_o = ~req_i[0];
    end
    last_d = last_q;
    if (update_i && valid_o) begin
      last_d = winner_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_access_arbiter.sv
// +----------------------------------------------------------------------+
// | regfile_access_arbiter: shares one register-file port set between     |
// | two requesters with a one-cycle issue and a valid/ready read reply    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module regfile_access_arbiter
  import regfile_access_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_ra_i,
  input  logic [AW-1:0] m0_rb_i,
  input  logic [AW-1:0] m0_wa_i,
  input  logic [DW-1:0] m0_wd_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  input  logic          m0_rrdy_i,
  output logic [DW-1:0] m0_rda_o,
  output logic [DW-1:0] m0_rdb_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_ra_i,
  input  logic [AW-1:0] m1_rb_i,
  input  logic [AW-1:0] m1_wa_i,
  input  logic [DW-1:0] m1_wd_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  input  logic          m1_rrdy_i,
  output logic [DW-1:0] m1_rda_o,
  output logic [DW-1:0] m1_rdb_o,
  output logic [AW-1:0] rf_ra_o,
  output logic [AW-1:0] rf_rb_o,
  output logic [AW-1:0] rf_wa_o,
  output logic [DW-1:0] rf_wd_o,
  output logic          rf_we_o,
  input  logic [DW-1:0] rf_da_i,
  input  logic [DW-1:0] rf_db_i
);

  logic [1:0]         req, we, rrdy;
  logic [1:0][AW-1:0] ra, rb, wa;
  logic [1:0][DW-1:0] wd;

  assign req  = {m1_req_i, m0_req_i};
  assign we   = {m1_we_i, m0_we_i};
  assign rrdy = {m1_rrdy_i, m0_rrdy_i};
  assign ra   = {m1_ra_i, m0_ra_i};
  assign rb   = {m1_rb_i, m0_rb_i};
  assign wa   = {m1_wa_i, m0_wa_i};
  assign wd   = {m1_wd_i, m0_wd_i};

  logic win, arb_valid, arb_update, wa_is_zero;

  arb_state_e         state_q, state_d;
  logic               sel_q, sel_d, wr_q, wr_d;
  logic [AW-1:0]      rf_ra_q, rf_ra_d, rf_rb_q, rf_rb_d, rf_wa_q, rf_wa_d;
  logic [DW-1:0]      rf_wd_q, rf_wd_d;
  logic               rf_we_q, rf_we_d;
  logic [1:0]         gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [1:0][DW-1:0] rda_q, rda_d, rdb_q, rdb_d;

  rr_arbiter2 u_rr_arbiter2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .update_i (arb_update),
    .valid_o  (arb_valid),
    .winner_o (win)
  );

  assign arb_update = (state_q == ST_IDLE);
  assign wa_is_zero = (int'(wa[win]) == REG_ZERO);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    rf_ra_d  = rf_ra_q;
    rf_rb_d  = rf_rb_q;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    rf_we_d  = 1'b0;
    gnt_d    = 2'b00;
    rvalid_d = rvalid_q;
    rda_d    = rda_q;
    rdb_d    = rdb_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          sel_d      = win;
          wr_d       = we[win];
          rf_ra_d    = ra[win];
          rf_rb_d    = rb[win];
          rf_wa_d    = wa[win];
          rf_wd_d    = wd[win];
          // A protected r0 write is still granted so the requester moves on.
          rf_we_d    = we[win] & ~(ZERO_PROTECT & wa_is_zero);
          gnt_d[win] = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          state_d = ST_IDLE;
        end else begin
          rda_d[sel_q]    = rf_da_i;
          rdb_d[sel_q]    = rf_db_i;
          rvalid_d[sel_q] = 1'b1;
          state_d         = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rrdy[sel_q]) begin
          rvalid_d[sel_q] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      rf_ra_q  <= '0;
      rf_rb_q  <= '0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
      rf_we_q  <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rda_q    <= '0;
      rdb_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      rf_ra_q  <= rf_ra_d;
      rf_rb_q  <= rf_rb_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
      rf_we_q  <= rf_we_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rda_q    <= rda_d;
      rdb_q    <= rdb_d;
    end
  end

  assign rf_ra_o     = rf_ra_q;
  assign rf_rb_o     = rf_rb_q;
  assign rf_wa_o     = rf_wa_q;
  assign rf_wd_o     = rf_wd_q;
  assign rf_we_o     = rf_we_q;
  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rda_o    = rda_q[0];
  assign m0_rdb_o    = rdb_q[0];
  assign m1_rda_o    = rda_q[1];
  assign m1_rdb_o    = rdb_q[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_regfile_access_arbiter: scoreboard bench with a behavioural regfile|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_access_arbiter;
  import regfile_access_arbiter_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req, we, rrdy;
  logic [AW-1:0] ra [2];
  logic [AW-1:0] rb [2];
  logic [AW-1:0] wa [2];
  logic [DW-1:0] wd [2];
  wire  [1:0]    gnt, rvalid;
  wire  [DW-1:0] rda [2];
  wire  [DW-1:0] rdb [2];
  wire  [AW-1:0] rf_ra, rf_rb, rf_wa;
  wire  [DW-1:0] rf_wd;
  wire           rf_we;
  logic [DW-1:0] rf_da, rf_db;
  logic [DW-1:0] regs [32] = '{default: '0};

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int            m;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Register file: write commits at posedge, reads latch at negedge.
  always @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wd;
  always @(negedge clk) begin
    rf_da <= regs[rf_ra];
    rf_db <= regs[rf_rb];
  end

  regfile_access_arbiter #(.AW(AW), .DW(DW), .ZERO_PROTECT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_ra_i(ra[0]), .m0_rb_i(rb[0]),
    .m0_wa_i(wa[0]), .m0_wd_i(wd[0]), .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]),
    .m0_rrdy_i(rrdy[0]), .m0_rda_o(rda[0]), .m0_rdb_o(rdb[0]),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_ra_i(ra[1]), .m1_rb_i(rb[1]),
    .m1_wa_i(wa[1]), .m1_wd_i(wd[1]), .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]),
    .m1_rrdy_i(rrdy[1]), .m1_rda_o(rda[1]), .m1_rdb_o(rdb[1]),
    .rf_ra_o(rf_ra), .rf_rb_o(rf_rb), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd), .rf_we_o(rf_we),
    .rf_da_i(rf_da), .rf_db_i(rf_db)
  );

  task automatic drive(input int m, input logic w, input logic [AW-1:0] a, b, waddr,
                       input logic [DW-1:0] d);
    req[m] = 1'b1; we[m] = w; ra[m] = a; rb[m] = b; wa[m] = waddr; wd[m] = d;
  endtask

  task automatic push_exp(input int m, input logic [DW-1:0] a, b);
    exp_t e;
    e.m = m; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input int m, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (gnt[m] !== 1'b1 && cyc < 20);
    req[m] = 1'b0;
    n_total++;
    if (gnt[m] !== 1'b1) $display("FAIL gnt_timeout m%0d: gnt=%b required 1", m, gnt[m]);
    else n_pass++;
  endtask

  task automatic wait_resp(input int m, input int hold, output int cyc);
    exp_t e;
    logic [DW-1:0] a0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (rvalid[m] !== 1'b1 && cyc < 20);
    n_total++;
    if (rvalid[m] !== 1'b1) $display("FAIL rvalid_timeout m%0d: rvalid=%b required 1", m, rvalid[m]);
    else n_pass++;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL resp_unexpected m%0d: scoreboard empty", m);
    end else begin
      e = exp_q.pop_front();
      if (e.m != m || rda[m] !== e.a || rdb[m] !== e.b)
        $display("FAIL resp_data: got m%0d %h/%h required m%0d %h/%h", m, rda[m], rdb[m], e.m, e.a, e.b);
      else n_pass++;
    end
    for (int i = 0; i < hold; i++) begin
      a0 = rda[m];
      @(negedge clk);
      n_total++;
      if (rvalid[m] !== 1'b1 || rda[m] !== a0 || gnt !== 2'b00)
        $display("FAIL resp_hold m%0d: rvalid=%b rda=%h gnt=%b required 1 %h 00", m, rvalid[m], rda[m], gnt, a0);
      else n_pass++;
    end
    rrdy[m] = 1'b1;
    @(negedge clk);
    rrdy[m] = 1'b0;
    n_total++;
    if (rvalid[m] !== 1'b0 || gnt !== 2'b00)
      $display("FAIL resp_clear m%0d: rvalid=%b gnt=%b required 0 00", m, rvalid[m], gnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    req = '0; we = '0; rrdy = '0;
    for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; wa[i] = '0; wd[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({gnt, rvalid, rf_we} !== 5'b0) $display("FAIL reset_ctrl: gnt/rvalid/we=%b required 0", {gnt, rvalid, rf_we});
    else n_pass++;
    n_total++;
    if ({rf_ra, rf_rb, rf_wa} !== '0 || rf_wd !== '0)
      $display("FAIL reset_rf: ra/rb/wa=%h wd=%h required 0", {rf_ra, rf_rb, rf_wa}, rf_wd);
    else n_pass++;
    n_total++;
    if ({rda[0], rdb[0], rda[1], rdb[1]} !== '0) $display("FAIL reset_rd: read data nonzero, required 0");
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int c;
    drive(0, 1'b1, 0, 0, 5, 32'hDEADBEEF);
    wait_gnt(0, c);
    n_total++;
    if (c != 1) $display("FAIL wr_gnt_latency: %0d required 1", c); else n_pass++;
    n_total++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF)
      $display("FAIL wr_issue: we=%b wa=%0d wd=%h required 1 5 deadbeef", rf_we, rf_wa, rf_wd);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rf_we !== 1'b0 || gnt !== 2'b00) $display("FAIL wr_pulse: we=%b gnt=%b required 0 00", rf_we, gnt);
    else n_pass++;
    drive(0, 1'b0, 5, 0, 0, 0);
    push_exp(0, 32'hDEADBEEF, 32'h0);
    wait_gnt(0, c);
    wait_resp(0, 0, c);
    n_total++;
    if (c != 1) $display("FAIL rd_latency: rvalid %0d cycles after gnt required 1", c); else n_pass++;
    // Back-to-back writes: the second request is already up during the first ISSUE.
    drive(0, 1'b1, 0, 0, 1, 32'd11);
    wait_gnt(0, c);
    drive(0, 1'b1, 0, 0, 2, 32'd22);
    wait_gnt(0, c);
    n_total++;
    if (c != 2) $display("FAIL b2b_write: gnt spacing %0d required 2", c); else n_pass++;
    @(negedge clk);
  endtask

  task automatic run_pair(input int first);
    int c;
    int other = 1 - first;
    drive(0, 1'b0, 1, 2, 0, 0);
    drive(1, 1'b0, 2, 5, 0, 0);
    if (first == 0) begin
      push_exp(0, 32'd11, 32'd22); push_exp(1, 32'd22, 32'hDEADBEEF);
    end else begin
      push_exp(1, 32'd22, 32'hDEADBEEF); push_exp(0, 32'd11, 32'd22);
    end
    wait_gnt(first, c);
    n_total++;
    if (c != 1 || gnt[other] !== 1'b0)
      $display("FAIL pair_first: m%0d gnt after %0d, other gnt=%b required 1 0", first, c, gnt[other]);
    else n_pass++;
    wait_resp(first, 0, c);
    wait_gnt(other, c);
    n_total++;
    if (c != 1) $display("FAIL pair_second: m%0d gnt after %0d required 1", other, c); else n_pass++;
    wait_resp(other, 0, c);
  endtask

  task automatic test_back_to_back();
    int c;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pair(0);
    drive(0, 1'b1, 0, 0, 9, 32'd9);
    wait_gnt(0, c);
    @(negedge clk);
    run_pair(1);
  endtask

  task automatic test_zero_protect();
    int c;
    drive(1, 1'b1, 0, 0, 0, 32'h12345678);
    wait_gnt(1, c);
    n_total++;
    if (c != 1 || rf_we !== 1'b0) $display("FAIL zp_issue: gnt after %0d we=%b required 1 0", c, rf_we);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rf_we !== 1'b0) $display("FAIL zp_after: we=%b required 0", rf_we); else n_pass++;
    drive(1, 1'b0, 0, 0, 0, 0);
    push_exp(1, 32'h0, 32'h0);
    wait_gnt(1, c);
    wait_resp(1, 0, c);
  endtask

  task automatic test_rrdy_hold();
    int c;
    drive(0, 1'b0, 5, 1, 0, 0);
    push_exp(0, 32'hDEADBEEF, 32'd11);
    wait_gnt(0, c);
    drive(1, 1'b1, 0, 0, 3, 32'hA5A50003);
    wait_resp(0, 4, c);
    wait_gnt(1, c);
    n_total++;
    if (c != 1 || rf_we !== 1'b1 || rf_wa !== 5'd3)
      $display("FAIL hold_pending: m1 gnt after %0d we=%b wa=%0d required 1 1 3", c, rf_we, rf_wa);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    int c;
    drive(0, 1'b1, 0, 0, 7, 32'd40);
    wait_gnt(0, c);
    @(negedge clk);
    drive(0, 1'b0, 7, 0, 0, 0);
    push_exp(0, 32'd40, 32'd0);
    wait_gnt(0, c);
    wait_resp(0, 0, c);
    drive(0, 1'b1, 0, 0, 7, 32'd99);
    wait_gnt(0, c);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (rf_we !== 1'b0) $display("FAIL rst_async_we: we=%b required 0", rf_we); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (gnt !== 2'b00 || rvalid !== 2'b00) $display("FAIL rst_release: gnt=%b rvalid=%b required 00 00", gnt, rvalid);
    else n_pass++;
    drive(0, 1'b0, 7, 0, 0, 0);
    push_exp(0, 32'd40, 32'd0);
    wait_gnt(0, c);
    wait_resp(0, 0, c);
  endtask

  task automatic test_drop_req();
    int c;
    logic seen = 1'b0;
    drive(0, 1'b0, 2, 1, 0, 0);
    push_exp(0, 32'd22, 32'd11);
    wait_gnt(0, c);
    @(negedge clk);
    drive(1, 1'b0, 1, 1, 0, 0);
    repeat (2) begin @(negedge clk); seen |= gnt[1]; end
    req[1] = 1'b0;
    wait_resp(0, 0, c);
    repeat (4) begin @(negedge clk); seen |= gnt[1] | rf_we; end
    n_total++;
    if (seen !== 1'b0) $display("FAIL drop_req: m1 gnt or we seen=%b required 0", seen); else n_pass++;
    drive(0, 1'b1, 0, 0, 9, 32'h99);
    wait_gnt(0, c);
    n_total++;
    if (c != 1) $display("FAIL drop_idle: m0 gnt after %0d required 1", c); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_zero_protect();
    test_rrdy_hold();
    test_reset_mid_issue();
    test_drop_req();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
